// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types, defaults and ring helpers for the one-hot round-robin arbiter.
package ring_rr_arbiter_pkg;

   localparam int unsigned N_DEF        = 4;
   localparam int unsigned MAX_HOLD_DEF = 8;
   localparam int unsigned RING_MAX     = 32;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   // Rotate an n-bit one-hot vector (n <= RING_MAX) right by one; bit 0 wraps to bit n-1.
   function automatic logic [RING_MAX-1:0] rotr1(input logic [RING_MAX-1:0] v,
                                                 input int unsigned         n);
      logic [RING_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < RING_MAX; i++) begin
         if (i + 1 < n) begin
            r[i] = v[i+1];
         end else if (i + 1 == n) begin
            r[i] = v[0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Combinational wrap-around picker: starts at the ptr bit and walks toward lower indices.
module rr_pick
   import ring_rr_arbiter_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic [N-1:0]         req_i,
   input  logic [N-1:0]         ptr_i,
   output logic [N-1:0]         win_o,
   output logic [$clog2(N)-1:0] win_id_o
);

   localparam int unsigned IDW = $clog2(N);

   always_comb begin
      int unsigned p;
      int unsigned idx;
      logic        found;
      p        = 0;
      idx      = 0;
      found    = 1'b0;
      win_o    = '0;
      win_id_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ptr_i[i]) p = i;
      end
      for (int unsigned k = 0; k < N; k++) begin
         idx = (p + N - k) % N;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            win_o[idx] = 1'b1;
            win_id_o   = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and bounded grant tenure.
module ring_rr_arbiter
   import ring_rr_arbiter_pkg::*;
#(
   parameter int unsigned N        = N_DEF,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic [N-1:0]         ptr
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
   localparam logic [N-1:0] PTR_RST = {1'b1, {(N-1){1'b0}}};

   state_e         state_q,  state_d;
   logic [N-1:0]   grant_q,  grant_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           busy_q,   busy_d;
   logic [N-1:0]   ptr_q,    ptr_d;
   logic [HW-1:0]  hold_q,   hold_d;

   logic [N-1:0]   win;
   logic [IDW-1:0] win_id;

   rr_pick #(.N(N)) u_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .win_o    (win),
      .win_id_o (win_id)
   );

   // Next-state: arbitrate in IDLE, count tenure and release in OWN.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d  = win;
               gnt_id_d = win_id;
               busy_d   = 1'b1;
               hold_d   = HW'(1);
               state_d  = OWN;
            end
         end
         OWN: begin
            if (!(|(req & grant_q)) || (hold_q == HW'(MAX_HOLD))) begin
               grant_d  = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               hold_d   = '0;
               ptr_d    = N'(rotr1(RING_MAX'(grant_q), N));
               state_d  = IDLE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= PTR_RST;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
      end
   end

   assign grant  = grant_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;
   assign ptr    = ptr_q;

endmodule
